// File: rtl/cpu_pkg.sv
// Shared frontend types: PC state machine states, next-PC source tags, default reset vector.
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    typedef enum logic [2:0] {
        NONE    = 3'd0,
        TRAP    = 3'd1,
        MISPRED = 3'd2,
        PRED    = 3'd3,
        SEQ     = 3'd4
    } redirect_src_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-PC bundle between pc_gen (master) and the frontend/redirect sources (slave).
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            fetch_ready;
    logic            pc_valid;
    logic [XLEN-1:0] pc;
    logic            pc_misaligned;
    logic            redirected;
    logic            trap_valid;
    logic [XLEN-1:0] trap_target;
    logic            mispredict_valid;
    logic [XLEN-1:0] mispredict_target;
    logic            predict_valid;
    logic [XLEN-1:0] predict_target;
    logic            halt_req;
    logic            resume_req;
    logic            halted;

    modport master (
        input  fetch_ready, trap_valid, trap_target, mispredict_valid, mispredict_target,
               predict_valid, predict_target, halt_req, resume_req,
        output pc_valid, pc, pc_misaligned, redirected, halted
    );

    modport slave (
        output fetch_ready, trap_valid, trap_target, mispredict_valid, mispredict_target,
               predict_valid, predict_target, halt_req, resume_req,
        input  pc_valid, pc, pc_misaligned, redirected, halted
    );

endinterface

// File: rtl/pc_redirect_arb.sv
// Combinational next-PC priority select: trap > mispredict > predict > sequential > hold.
// Zero latency; predict and sequential advance only when the current PC is accepted.
module pc_redirect_arb
    import cpu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STEP   = 4,
    parameter int IALIGN = 4
) (
    input  logic            i_accept,
    input  logic [XLEN-1:0] i_cur_pc,
    input  logic            i_trap_valid,
    input  logic [XLEN-1:0] i_trap_target,
    input  logic            i_mispredict_valid,
    input  logic [XLEN-1:0] i_mispredict_target,
    input  logic            i_predict_valid,
    input  logic [XLEN-1:0] i_predict_target,
    output logic [XLEN-1:0] o_next_pc,
    output redirect_src_t   o_src,
    output logic            o_misaligned
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);

    always_comb begin
        o_next_pc    = i_cur_pc;
        o_src        = NONE;
        o_misaligned = 1'b0;
        if (i_trap_valid) begin
            o_next_pc    = i_trap_target;
            o_src        = TRAP;
            o_misaligned = |(i_trap_target & ALIGN_MASK);
        end else if (i_mispredict_valid) begin
            o_next_pc    = i_mispredict_target;
            o_src        = MISPRED;
            o_misaligned = |(i_mispredict_target & ALIGN_MASK);
        end else if (i_predict_valid && i_accept) begin
            o_next_pc    = i_predict_target;
            o_src        = PRED;
            o_misaligned = |(i_predict_target & ALIGN_MASK);
        end else if (i_accept) begin
            // wraps modulo 2^XLEN by construction
            o_next_pc = i_cur_pc + STEP_INC;
            o_src     = SEQ;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator with BOOT/RUN/HALT control; all outputs registered, redirects visible next cycle.
// PC holds while pc_valid && !fetch_ready; trap/mispredict override the stall and the halt state.
module pc_gen
    import cpu_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int              STEP         = 4,
    parameter int              IALIGN       = 4
) (
    input logic      clk,
    input logic      rst,
    pc_gen_if.master bus
);

    localparam logic [1:0] ST_BOOT = BOOT;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_HALT = HALT;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_pc_valid;
    logic            r_misaligned;
    logic            r_redirected;
    logic            r_halted;

    logic [1:0]      w_state_nxt;
    logic            w_accept;
    logic [XLEN-1:0] w_next_pc;
    redirect_src_t   w_src;
    logic            w_misaligned;
    logic            w_target_load;

    assign w_accept = r_pc_valid & bus.fetch_ready;

    pc_redirect_arb #(
        .XLEN   (XLEN),
        .STEP   (STEP),
        .IALIGN (IALIGN)
    ) u_arb (
        .i_accept            (w_accept),
        .i_cur_pc            (r_pc),
        .i_trap_valid        (bus.trap_valid),
        .i_trap_target       (bus.trap_target),
        .i_mispredict_valid  (bus.mispredict_valid),
        .i_mispredict_target (bus.mispredict_target),
        .i_predict_valid     (bus.predict_valid),
        .i_predict_target    (bus.predict_target),
        .o_next_pc           (w_next_pc),
        .o_src               (w_src),
        .o_misaligned        (w_misaligned)
    );

    assign w_target_load = (w_src == TRAP) || (w_src == MISPRED) || (w_src == PRED);

    // halt_req beats resume_req when both arrive in HALT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN:  if (bus.halt_req) w_state_nxt = ST_HALT;
            ST_HALT: if (bus.resume_req && !bus.halt_req) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_VECTOR;
            r_pc_valid   <= 1'b0;
            r_misaligned <= 1'b0;
            r_redirected <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_next_pc;
            r_pc_valid   <= (w_state_nxt == ST_RUN);
            r_halted     <= (w_state_nxt == ST_HALT);
            r_redirected <= w_target_load;
            if (w_target_load) begin
                r_misaligned <= w_misaligned;
            end
        end
    end

    assign bus.pc            = r_pc;
    assign bus.pc_valid      = r_pc_valid;
    assign bus.pc_misaligned = r_misaligned;
    assign bus.redirected    = r_redirected;
    assign bus.halted        = r_halted;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed walk through the fetch scenarios, then random traffic against a reference model.
module tb_pc_gen;
    import cpu_pkg::*;

    localparam int          XLEN = 32;
    localparam logic [31:0] RV   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(XLEN)) bif ();

    pc_gen #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .STEP         (4),
        .IALIGN       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc;
    logic        m_valid, m_mis, m_redir, m_halted;
    string       m_mode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_load(input logic [31:0] t);
        m_pc    = t;
        m_redir = 1'b1;
        m_mis   = (t % 4) != 0;
    endtask

    task automatic step(input logic r, input logic fr,
                        input logic tv, input logic [31:0] tt,
                        input logic mv, input logic [31:0] mt,
                        input logic pv, input logic [31:0] pt,
                        input logic hr, input logic rr);
        logic acc;
        rst                   = r;
        bif.fetch_ready       = fr;
        bif.trap_valid        = tv;
        bif.trap_target       = tt;
        bif.mispredict_valid  = mv;
        bif.mispredict_target = mt;
        bif.predict_valid     = pv;
        bif.predict_target    = pt;
        bif.halt_req          = hr;
        bif.resume_req        = rr;
        if (r) begin
            m_pc = RV; m_valid = 1'b0; m_mis = 1'b0; m_redir = 1'b0; m_halted = 1'b0;
            m_mode = "BOOT";
        end else begin
            acc = m_valid && fr;
            if (tv)             model_load(tt);
            else if (mv)        model_load(mt);
            else if (pv && acc) model_load(pt);
            else begin
                m_redir = 1'b0;
                if (acc) m_pc = m_pc + 32'd4;
            end
            if (m_mode == "BOOT")                  m_mode = "RUN";
            else if (m_mode == "RUN" && hr)        m_mode = "HALT";
            else if (m_mode == "HALT" && rr && !hr) m_mode = "RUN";
            m_valid  = (m_mode == "RUN");
            m_halted = (m_mode == "HALT");
        end
        @(posedge clk);
        #1;
        check("pc",            bif.pc,                    m_pc);
        check("pc_valid",      32'(bif.pc_valid),         32'(m_valid));
        check("pc_misaligned", 32'(bif.pc_misaligned),    32'(m_mis));
        check("redirected",    32'(bif.redirected),       32'(m_redir));
        check("halted",        32'(bif.halted),           32'(m_halted));
    endtask

    task automatic idle(input logic fr);
        step(1'b0, fr, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    initial begin
        // reset and boot
        step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        check("reset_pc_valid", 32'(bif.pc_valid), 32'd0);
        // halt_req during BOOT must be ignored
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        check("first_fetch_pc", bif.pc, RV);
        check("first_fetch_valid", 32'(bif.pc_valid), 32'd1);
        idle(1'b1);
        idle(1'b1);
        check("seq_pc8", bif.pc, 32'h8);
        idle(1'b1);
        idle(1'b1);
        check("at_0x10", bif.pc, 32'h10);

        // stall, mispredict in the second stall cycle
        idle(1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h200, 1'b0, 0, 1'b0, 1'b0);
        check("mispred_pc", bif.pc, 32'h200);
        check("mispred_redir", 32'(bif.redirected), 32'd1);
        idle(1'b0);

        // simultaneous redirects, then ignored predict while stalled
        step(1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 32'h300, 1'b1, 32'h400, 1'b0, 1'b0);
        check("trap_wins", bif.pc, 32'h8000_0000);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 32'h500, 1'b0, 1'b0);

        // misaligned predict target is sticky across sequential steps
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 32'h102, 1'b0, 1'b0);
        check("misalign_pc", bif.pc, 32'h102);
        check("misalign_flag", 32'(bif.pc_misaligned), 32'd1);
        idle(1'b1);
        idle(1'b1);
        check("misalign_sticky", 32'(bif.pc_misaligned), 32'd1);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 32'h200, 1'b0, 1'b0);

        // halt, redirect while halted, halt+resume together, resume
        step(1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h20, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        check("halted", 32'(bif.halted), 32'd1);
        step(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        check("resume_pc", bif.pc, 32'h40);
        check("resume_valid", 32'(bif.pc_valid), 32'd1);

        // wrap-around, then reset during a redirect
        step(1'b0, 1'b1, 1'b0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0, 0, 1'b0, 1'b0);
        idle(1'b1);
        check("wrap_pc", bif.pc, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h1234, 1'b1, 32'h5678, 1'b0, 0, 1'b0, 1'b0);
        check("rst_mid_pc", bif.pc, RV);
        idle(1'b1);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 11) == 0, rand_target(),
                 $urandom_range(0, 7) == 0,  rand_target(),
                 $urandom_range(0, 3) == 0,  rand_target(),
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 5) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage of each core. Holds the current fetch PC and advances it sequentially on accepted fetches. Accepts prioritised redirects from the trap unit, the branch-resolution stage and the fetch-stage predictor. Adds a valid/ready fetch handshake, a run/halt state machine for debug, and misaligned-target flagging, none of which the plain PC register provides.

## Interface
Parameters:
- XLEN, 32, PC and target width.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- STEP, 4, sequential increment in bytes.
- IALIGN, 4, required target alignment in bytes (2 or 4); used only for flagging.

Ports. Clock is `clk`; reset is `rst`, synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fetch_ready  in  1  fetch stage accepts `pc` this cycle
- pc_valid  out  1  `pc` is a valid fetch request
- pc  out  XLEN  current fetch PC
- pc_misaligned  out  1  `pc` came from a target violating IALIGN
- redirected  out  1  `pc` was loaded from a redirect last cycle (frontend kill)
- trap_valid  in  1  trap/exception redirect
- trap_target  in  XLEN  trap vector
- mispredict_valid  in  1  branch-resolution redirect
- mispredict_target  in  XLEN  corrected target
- predict_valid  in  1  predictor says the current `pc` is taken
- predict_target  in  XLEN  predicted target
- halt_req  in  1  enter HALT
- resume_req  in  1  leave HALT
- halted  out  1  state == HALT

## Operation
- States: BOOT, RUN, HALT.
  - BOOT: `pc_valid`=0; always moves to RUN next cycle.
  - RUN: `pc_valid`=1.
  - HALT: `pc_valid`=0 and `halted`=1.
- Transitions:
  - RUN→HALT on `halt_req`.
  - HALT→RUN on `resume_req`.
  - `halt_req` in HALT or BOOT is ignored.
  - `resume_req` outside HALT is ignored.
  - If `halt_req` and `resume_req` arrive together, `halt_req` wins.
- Next-PC priority, highest first:
  1. trap
  2. mispredict
  3. predict (only if `pc_valid && fetch_ready`)
  4. sequential `pc + STEP` (only if `pc_valid && fetch_ready`)
  5. hold
- Trap and mispredict are taken in any state, regardless of `fetch_ready`.
- In HALT, a trap or mispredict updates `pc` but the state stays HALT.
- A trap or mispredict in the same cycle as `halt_req` loads the target and enters HALT.
- `redirected` is registered 1 when the load came from trap, mispredict or predict; otherwise 0.
- `pc_misaligned` is registered 1 when a loaded target has `target % IALIGN != 0`. The target is loaded unmodified; the trap unit handles the fault. Sequential and hold cycles keep the flag's previous value.
- Arithmetic is modulo 2^XLEN: `pc = 2^XLEN - STEP` wraps to 0, with no flag.

## Timing
- Reset values: `pc`=RESET_VECTOR, `pc_valid`=0, `pc_misaligned`=0, `redirected`=0, `halted`=0, state BOOT.
- First valid fetch: the cycle after `rst` deasserts, with `pc`=RESET_VECTOR.
- All outputs are registered. A redirect sampled in cycle N is visible on `pc` in cycle N+1, with `redirected`=1 in cycle N+1.
- Handshake: `pc` and `pc_valid` are stable while `pc_valid && !fetch_ready` unless a trap or mispredict arrives.
- Reset asserted mid-operation overrides every input in that cycle.

## Structure
- The shared `cpu_pkg` carries:
  - the `pc_state_t` enum (BOOT, RUN, HALT);
  - the `redirect_src_t` enum (NONE, TRAP, MISPRED, PRED, SEQ);
  - the default RESET_VECTOR constant.
- One sub-module, `pc_redirect_arb`: a combinational priority select producing the next PC, source and misaligned bit. The state machine and registers live in `pc_gen`.

## Test plan
- Reset, then `fetch_ready`=1 held → `pc` sequence 0x0 (valid from cycle 1), 0x4, 0x8; `pc_valid`=0 during BOOT.
- `fetch_ready`=0 for 3 cycles at `pc`=0x10 → `pc` holds 0x10. A mispredict to 0x200 in the 2nd stall cycle → next cycle `pc`=0x200, `redirected`=1.
- Same cycle: trap to 0x8000_0000, mispredict to 0x300, predict to 0x400 → `pc`=0x8000_0000. Predict only, with `fetch_ready`=0 → ignored.
- Predict to 0x102 with IALIGN=4 → `pc`=0x102, `pc_misaligned`=1. Later sequential steps keep it 1 until the next load of an aligned target.
- `halt_req` at `pc`=0x20 → `halted`=1, `pc_valid`=0. A trap to 0x40 while halted → `pc`=0x40, still halted. `resume_req` → RUN, `pc_valid`=1 at 0x40.
- `pc`=0xFFFF_FFFC, accepted → `pc`=0x0. `rst` pulsed mid-redirect → `pc`=RESET_VECTOR, state BOOT.
